fpu_addsub_sequencer: RTL and testbench

//  Handshaked front/back end for the multi-cycle FP add/subtract core. Accepts one

---
 rtl/fpu_seq_pkg.sv | 20 ++
 rtl/fpu_addsub_sequencer.sv | 151 +++++++++++++++
 tb/tb_fpu_addsub_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_seq_pkg.sv
// Shared state encoding, rounding-mode codes and counter sizing for the FP add/sub sequencer.
package fpu_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_OUT    = 2'd3
    } seq_state_e;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    function automatic int cnt_w(input int to_cyc);
        return $clog2(to_cyc + 1);
    endfunction

endpackage

// File: rtl/fpu_addsub_sequencer.sv
// Valid/ready front/back end around the multi-cycle FP add/sub core; one op in flight.
// Optional watchdog abort in WAIT is enabled by defining SEQ_WATCHDOG_EN.
module fpu_addsub_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int W      = 32,
    parameter int TO_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic         in_op,
    input  logic [1:0]   in_rmode,
    output logic         core_beg,
    output logic         core_rst_fsm,
    output logic [W-1:0] core_x,
    output logic [W-1:0] core_y,
    output logic         core_op,
    output logic [1:0]   core_rmode,
    input  logic         core_ready,
    input  logic [W-1:0] core_result,
    input  logic         core_ovf,
    input  logic         core_unf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_ovf,
    output logic         out_unf,
    output logic         out_timeout
);

    seq_state_e   state_q, state_d;
    logic [W-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
    logic         op_q, op_d, ovf_q, ovf_d, unf_q, unf_d, tmo_q, tmo_d;
    logic [1:0]   rm_q, rm_d;

`ifdef SEQ_WATCHDOG_EN
    localparam int CNT_W = cnt_w(TO_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= 1'b0;
            rm_q    <= 2'd0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            rm_q    <= rm_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            tmo_q   <= tmo_d;
`ifdef SEQ_WATCHDOG_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        op_d         = op_q;
        rm_d         = rm_q;
        res_d        = res_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        tmo_d        = tmo_q;
        core_beg     = 1'b0;
        core_rst_fsm = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    op_d    = in_op;
                    rm_d    = in_rmode;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                core_beg = 1'b1;
                state_d  = S_WAIT;
`ifdef SEQ_WATCHDOG_EN
                cnt_d    = '0;
`endif
            end
            S_WAIT: begin
                if (core_ready) begin
                    core_rst_fsm = 1'b1;
                    res_d        = core_result;
                    ovf_d        = core_ovf;
                    unf_d        = core_unf;
                    tmo_d        = 1'b0;
                    state_d      = S_OUT;
                end
`ifdef SEQ_WATCHDOG_EN
                // cnt_q counts completed WAIT cycles; abort on the TO_CYC-th one
                else if (cnt_q == CNT_W'(TO_CYC - 1)) begin
                    core_rst_fsm = 1'b1;
                    res_d        = '0;
                    ovf_d        = 1'b0;
                    unf_d        = 1'b0;
                    tmo_d        = 1'b1;
                    state_d      = S_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_OUT: begin
                if (out_ready) begin
                    tmo_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign core_x      = x_q;
    assign core_y      = y_q;
    assign core_op     = op_q;
    assign core_rmode  = rm_q;
    assign out_result  = res_q;
    assign out_ovf     = ovf_q;
    assign out_unf     = unf_q;
    assign out_timeout = tmo_q;

endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// Directed bench for fpu_addsub_sequencer; the bench plays the role of the FP core.
module tb_fpu_addsub_sequencer;

`ifdef SEQ_WATCHDOG_EN
    localparam int TOC = 16;
`else
    localparam int TOC = 64;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, in_op = 1'b0;
    logic [31:0] in_x = '0, in_y = '0;
    logic [1:0]  in_rmode = 2'd0;
    logic        core_beg, core_rst_fsm, core_op;
    logic [31:0] core_x, core_y, core_result = '0;
    logic [1:0]  core_rmode;
    logic        core_ready = 1'b0, core_ovf = 1'b0, core_unf = 1'b0;
    logic        out_valid, out_ready = 1'b0, out_ovf, out_unf, out_timeout;
    logic [31:0] out_result;

    int checks = 0, errors = 0;
    int beg_cnt = 0, rstf_cnt = 0, viol = 0;
    logic prev_beg = 1'b0, prev_rstf = 1'b0;

    fpu_addsub_sequencer #(.W(32), .TO_CYC(TOC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_op(in_op), .in_rmode(in_rmode),
        .core_beg(core_beg), .core_rst_fsm(core_rst_fsm), .core_x(core_x),
        .core_y(core_y), .core_op(core_op), .core_rmode(core_rmode),
        .core_ready(core_ready), .core_result(core_result), .core_ovf(core_ovf),
        .core_unf(core_unf),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    // Strobe pulse counting and back-to-back strobe detection
    always @(posedge clk) begin
        if (rst) begin
            prev_beg  <= 1'b0;
            prev_rstf <= 1'b0;
        end else begin
            beg_cnt   <= beg_cnt + int'(core_beg);
            rstf_cnt  <= rstf_cnt + int'(core_rst_fsm);
            if ((core_beg && prev_beg) || (core_rst_fsm && prev_rstf)) viol <= viol + 1;
            prev_beg  <= core_beg;
            prev_rstf <= core_rst_fsm;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] bx [3];
    logic [31:0] by [3];
    logic        bop [3];
    logic [31:0] bres [3];
    int          exp_beg;

    initial begin
        bx[0] = 32'h3F800000; by[0] = 32'h3F800000; bop[0] = 1'b0; bres[0] = 32'h40000000;
        bx[1] = 32'h40400000; by[1] = 32'h3F800000; bop[1] = 1'b1; bres[1] = 32'h40000000;
        bx[2] = 32'h40000000; by[2] = 32'h40000000; bop[2] = 1'b0; bres[2] = 32'h40800000;

        // Reset state
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_core_beg", 64'(core_beg), 64'd0);
        chk("rst_core_rst_fsm", 64'(core_rst_fsm), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_core_x", 64'(core_x), 64'd0);
        chk("rst_out_timeout", 64'(out_timeout), 64'd0);
        step();
        rst = 1'b0;

        // core_ready and out_ready while idle are ignored
        core_ready = 1'b1; out_ready = 1'b1;
        #1;
        chk("idle_ready_ignored", 64'(core_rst_fsm), 64'd0);
        step();
        chk("idle_no_out_valid", 64'(out_valid), 64'd0);
        chk("idle_still_ready", 64'(in_ready), 64'd1);
        core_ready = 1'b0; out_ready = 1'b0;

        // Single add 1.0 + 2.0
        in_valid = 1'b1; in_x = 32'h3F800000; in_y = 32'h40000000; in_op = 1'b0; in_rmode = 2'd1;
        step();
        in_valid = 1'b0; in_x = '0; in_y = '0; in_rmode = 2'd0;
        chk("add_launch_beg", 64'(core_beg), 64'd1);
        chk("add_launch_busy", 64'(in_ready), 64'd0);
        chk("add_core_x", 64'(core_x), 64'h3F800000);
        chk("add_core_y", 64'(core_y), 64'h40000000);
        chk("add_core_rmode", 64'(core_rmode), 64'd1);
        step();
        chk("add_wait_beg_low", 64'(core_beg), 64'd0);
        step(); step();
        chk("add_wait_no_valid", 64'(out_valid), 64'd0);
        chk("add_wait_x_stable", 64'(core_x), 64'h3F800000);
        core_ready = 1'b1; core_result = 32'h40400000;
        #1;
        chk("add_rst_fsm", 64'(core_rst_fsm), 64'd1);
        step();
        core_ready = 1'b0; core_result = 32'hDEADBEEF;
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_out_result", 64'(out_result), 64'h40400000);
        chk("add_out_flags", 64'({out_ovf, out_unf}), 64'd0);
        chk("add_beg_count", 64'(beg_cnt), 64'd1);

        // Backpressure with a new op waiting
        in_valid = 1'b1; in_x = 32'h11111111;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_result", 64'(out_result), 64'h40400000);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        chk("bp_no_second_beg", 64'(beg_cnt), 64'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_xfer_in_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b0;
        chk("bp_after_out_valid", 64'(out_valid), 64'd0);
        chk("bp_after_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back: in_valid held, out_ready held
        exp_beg = beg_cnt;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_x = bx[i]; in_y = by[i]; in_op = bop[i];
            #1;
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
            step();
            in_x = 32'hFFFFFFFF; in_y = 32'hFFFFFFFF;
            chk("b2b_beg", 64'(core_beg), 64'd1);
            step(); step();
            chk("b2b_x_stable", 64'(core_x), 64'(bx[i]));
            chk("b2b_y_stable", 64'(core_y), 64'(by[i]));
            chk("b2b_op_stable", 64'(core_op), 64'(bop[i]));
            core_ready = 1'b1; core_result = bres[i];
            step();
            core_ready = 1'b0;
            chk("b2b_result", 64'(out_result), 64'(bres[i]));
            chk("b2b_no_accept_in_out", 64'(in_ready), 64'd0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_beg_count", 64'(beg_cnt - exp_beg), 64'd3);
        chk("b2b_rstf_count", 64'(rstf_cnt - exp_beg), 64'd3);

        // Overflow; core_ready already high in LAUNCH must not capture there
        in_valid = 1'b1; in_x = 32'h7F7FFFFF; in_y = 32'h7F7FFFFF; in_op = 1'b0;
        step();
        in_valid = 1'b0;
        core_ready = 1'b1; core_result = 32'h7F800000; core_ovf = 1'b1;
        #1;
        chk("ovf_launch_ignores_ready", 64'(core_rst_fsm), 64'd0);
        step();
        chk("ovf_wait_rst_fsm", 64'(core_rst_fsm), 64'd1);
        step();
        core_ready = 1'b0; core_ovf = 1'b0; core_result = '0;
        chk("ovf_flag", 64'(out_ovf), 64'd1);
        chk("ovf_result", 64'(out_result), 64'h7F800000);
        step(); step();
        chk("ovf_flag_held", 64'({out_valid, out_ovf, out_unf}), 64'b110);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset two cycles after core_beg
        in_valid = 1'b1; in_x = 32'h3F800000; in_y = 32'h3F800000;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        chk("rstw_in_ready", 64'(in_ready), 64'd1);
        chk("rstw_out_valid", 64'(out_valid), 64'd0);
        chk("rstw_strobes", 64'({core_beg, core_rst_fsm}), 64'd0);
        chk("rstw_core_x", 64'(core_x), 64'd0);
        step();
        rst = 1'b0;
        in_valid = 1'b1; in_x = 32'h40000000; in_y = 32'h3F800000; in_op = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rstw_next_beg", 64'(core_beg), 64'd1);
        step();
        core_ready = 1'b1; core_result = 32'h3F800000; core_unf = 1'b1;
        step();
        core_ready = 1'b0; core_unf = 1'b0;
        chk("rstw_next_result", 64'(out_result), 64'h3F800000);
        chk("rstw_next_unf", 64'({out_valid, out_unf}), 64'b11);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("rstw_next_done", 64'({out_valid, in_ready}), 64'b01);

`ifdef SEQ_WATCHDOG_EN
        begin
            int k;
            int hit;
            in_valid = 1'b1; in_x = 32'h3F800000; in_y = 32'h3F800000;
            step();
            in_valid = 1'b0;
            step();
            hit = 0;
            for (k = 1; k <= 100 && hit == 0; k++) begin
                #1;
                if (core_rst_fsm) hit = k;
                else step();
            end
            chk("wd_cycle", 64'(hit), 64'd16);
            step();
            chk("wd_out_valid", 64'(out_valid), 64'd1);
            chk("wd_timeout", 64'(out_timeout), 64'd1);
            chk("wd_result", 64'(out_result), 64'd0);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk("wd_timeout_clear", 64'(out_timeout), 64'd0);
        end
`else
        chk("timeout_tied_low", 64'(out_timeout), 64'd0);
`endif

        step();
        chk("strobe_never_consecutive", 64'(viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
